mbr_mem_arbiter: RTL and testbench

MBR_MEM_ARBITER -- requirements
Module: mbr_mem_arbiter

---
 rtl/mbr_mem_arbiter_if.sv | 26 ++
 rtl/mbr_mem_arbiter.sv | 84 ++++++++
 tb/tb_mbr_mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mbr_mem_arbiter_if.sv
// mbr_mem_arbiter_if: requester and memory handshake bundle for the MBR memory arbiter.
interface mbr_mem_arbiter_if;
    logic        f_req;
    logic [15:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic        C3;
    logic        C11;
    logic        f_done;
    logic        d_done;
    logic        err;
    logic        busy;
    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, mem_ack,
        input  mem_req, mem_we, mem_addr, C3, C11, f_done, d_done, err, busy
    );
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, mem_ack,
        output mem_req, mem_we, mem_addr, C3, C11, f_done, d_done, err, busy
    );
endinterface

// File: rtl/mbr_mem_arbiter.sv
// mbr_mem_arbiter: round-robin fetch/data arbiter driving one memory port with ack timeout.
module mbr_mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    mbr_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WSTAGE, ACCESS, DONE} state_t;
    localparam logic [7:0] LIM = 8'(TIMEOUT - 1);
    state_t      state_q;
    logic [15:0] addr_q;
    logic [7:0]  cnt_q;
    logic        we_q, gnt_q, last_q;
    logic        mem_req_q, c11_q, f_done_q, d_done_q, err_q;
    logic        gnt_d, we_d;
    logic [15:0] addr_d;
    always_comb begin
        gnt_d  = (bus.f_req && bus.d_req) ? ~last_q : bus.d_req;
        addr_d = gnt_d ? bus.d_addr : bus.f_addr;
        we_d   = gnt_d & bus.d_we;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            mem_req_q <= 1'b0;
            c11_q     <= 1'b0;
            f_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            c11_q    <= 1'b0;
            f_done_q <= 1'b0;
            d_done_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: if (bus.f_req || bus.d_req) begin
                    gnt_q  <= gnt_d;
                    last_q <= gnt_d;
                    addr_q <= addr_d;
                    we_q   <= we_d;
                    cnt_q  <= '0;
                    if (we_d) begin
                        state_q <= WSTAGE;
                        c11_q   <= 1'b1;
                    end else begin
                        state_q   <= ACCESS;
                        mem_req_q <= 1'b1;
                    end
                end
                WSTAGE: begin
                    state_q   <= ACCESS;
                    mem_req_q <= 1'b1;
                end
                // an ack arriving on the limit cycle still completes normally
                ACCESS: if (bus.mem_ack || cnt_q == LIM) begin
                    state_q   <= DONE;
                    mem_req_q <= 1'b0;
                    f_done_q  <= ~gnt_q;
                    d_done_q  <= gnt_q;
                    err_q     <= ~bus.mem_ack;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_we   = mem_req_q & we_q;
    assign bus.mem_addr = mem_req_q ? addr_q : '0;
    // C3 suppressed while reset is pending so an aborted read never loads the MBR
    assign bus.C3       = (state_q == ACCESS) & bus.mem_ack & ~we_q & ~rst;
    assign bus.C11      = c11_q;
    assign bus.f_done   = f_done_q;
    assign bus.d_done   = d_done_q;
    assign bus.err      = err_q;
    assign bus.busy     = state_q != IDLE;
endmodule

// File: tb/tb_mbr_mem_arbiter.sv
// tb_mbr_mem_arbiter: directed and randomized transactions checked against a cycle-schedule model.
module tb_mbr_mem_arbiter;
    localparam int TIMEOUT = 15;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    logic last = 1'b1;
    mbr_mem_arbiter_if bus();
    mbr_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [23:0] pk(input logic mreq, mwe, input logic [15:0] maddr,
                                       input logic c3, c11, fd, dd, er, bz);
        return {mreq, mwe, maddr, c3, c11, fd, dd, er, bz};
    endfunction
    function automatic logic [23:0] obs();
        return pk(bus.mem_req, bus.mem_we, bus.mem_addr, bus.C3, bus.C11,
                  bus.f_done, bus.d_done, bus.err, bus.busy);
    endfunction
    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (req,we,addr,C3,C11,fd,dd,err,busy)", tag, got, exp);
        end
    endtask
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.f_req = 1'b0;
            bus.d_req = 1'b0;
            bus.f_addr = 16'($urandom);
            bus.d_addr = 16'($urandom);
            bus.mem_ack = 1'($urandom);
            #1 chk("idle", obs(), '0);
        end
    endtask
    // k >= TIMEOUT means mem_ack never comes; rst_at >= 0 resets in that ACCESS cycle
    task automatic do_txn(input logic fr, dr, input logic [15:0] fa, da, input logic dwe,
                          input int k, input int rst_at);
        logic g, we, to, ack_now;
        logic [15:0] a;
        int acc0, n, j;
        g    = (fr && dr) ? ~last : dr;
        we   = g & dwe;
        a    = g ? da : fa;
        to   = (k >= TIMEOUT);
        n    = to ? TIMEOUT : k + 1;
        acc0 = we ? 2 : 1;
        @(negedge clk);
        bus.f_req = fr;
        bus.d_req = dr;
        bus.f_addr = fa;
        bus.d_addr = da;
        bus.d_we = dwe;
        bus.mem_ack = 1'($urandom);
        #1 chk("grant", obs(), '0);
        last = g;
        for (int c = 1; c <= acc0 + n; c++) begin
            @(negedge clk);
            j = c - acc0;
            if (c == acc0 + n) begin
                bus.f_req = 1'b0;
                bus.d_req = 1'b0;
                bus.mem_ack = 1'($urandom);
                #1 chk("done", obs(), pk(0, 0, 16'h0, 0, 0, ~g, g, to, 1));
            end else if (c < acc0) begin
                bus.f_req = 1'($urandom);
                bus.d_req = 1'($urandom);
                bus.mem_ack = 1'($urandom);
                #1 chk("wstage", obs(), pk(0, 0, 16'h0, 0, 1, 0, 0, 0, 1));
            end else if (j == rst_at) begin
                rst = 1'b1;
                bus.f_req = 1'b0;
                bus.d_req = 1'b0;
                bus.mem_ack = 1'b0;
                #1 chk("pre_rst", obs(), pk(1, we, a, 0, 0, 0, 0, 0, 1));
                @(negedge clk);
                rst = 1'b0;
                #1 chk("post_rst", obs(), '0);
                last = 1'b1;
                return;
            end else begin
                ack_now = !to && j == k;
                bus.f_req = 1'($urandom);
                bus.d_req = 1'($urandom);
                bus.f_addr = 16'($urandom);
                bus.d_addr = 16'($urandom);
                bus.d_we = 1'($urandom);
                bus.mem_ack = ack_now;
                #1 chk("access", obs(), pk(1, we, a, ack_now & ~we, 0, 0, 0, 0, 1));
            end
        end
    endtask
    initial begin
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        bus.f_addr = '0;
        bus.d_addr = '0;
        bus.d_we = 1'b0;
        bus.mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("reset", obs(), '0);
        rst = 1'b0;
        do_txn(1, 0, 16'h0040, 16'h0, 0, 1, -1);
        do_txn(0, 1, 16'h0, 16'h1234, 1, 0, -1);
        idle_cycles(1);
        for (int i = 0; i < 4; i++) do_txn(1, 1, 16'(16'h100 + i), 16'(16'h200 + i), 0, 0, -1);
        do_txn(0, 1, 16'h0, 16'h5555, 0, TIMEOUT + 5, -1);
        idle_cycles(1);
        do_txn(1, 0, 16'hbeef, 16'h0, 0, TIMEOUT - 1, -1);
        do_txn(0, 1, 16'h0, 16'h7777, 1, TIMEOUT - 1, -1);
        do_txn(1, 0, 16'h0abc, 16'h0, 0, 3, 1);
        do_txn(1, 0, 16'h0abc, 16'h0, 0, 0, -1);
        for (int i = 0; i < 150; i++) begin
            logic fr, dr;
            fr = 1'($urandom);
            dr = 1'($urandom);
            if (!fr && !dr) fr = 1'b1;
            do_txn(fr, dr, 16'($urandom), 16'($urandom), 1'($urandom),
                   $urandom_range(0, TIMEOUT + 2),
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
